// File: rtl/rs232_rx_buf.sv
// Show-ahead receive FIFO behind an RS232 receiver with a one-pulse-per-byte acknowledge.
// Optional sticky overrun flag is enabled by defining RS232_RX_BUF_OVR_EN.
module rs232_rx_buf #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              rx_done,
    input  logic              rd,
    output logic [7:0]        rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              ovr,
    input  logic              ovr_clr
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic              cap;
    logic              rd_eff;
    logic              wr;
    logic              drop;

    // The ~rx_done term keeps a still-high rx_rdy from being captured twice.
    assign cap     = rx_rdy & ~rx_done;
    assign rd_eff  = rd & ~empty;
    assign wr      = cap & (~full | rd_eff);
    assign drop    = cap & full & ~rd_eff;
    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign rd_data = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            rx_done <= 1'b0;
        end else begin
            rx_done <= cap;
            if (wr)
                wptr <= wptr + 1'b1;
            if (rd_eff)
                rptr <= rptr + 1'b1;
            case ({wr, rd_eff})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage is deliberately not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr && !rst)
            mem[wptr] <= rx_data;
    end

`ifdef RS232_RX_BUF_OVR_EN
    always_ff @(posedge clk) begin
        if (rst)
            ovr <= 1'b0;
        else if (drop)
            ovr <= 1'b1;
        else if (ovr_clr)
            ovr <= 1'b0;
    end
`else
    logic unused_ovr;
    assign unused_ovr = ovr_clr | drop;
    assign ovr        = 1'b0;
`endif
endmodule

// File: tb/tb_rs232_rx_buf.sv
// Self-checking bench for rs232_rx_buf: directed scenarios then random traffic,
// each cycle compared against a queue-based reference model.
module tb_rs232_rx_buf;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            rx_rdy = 1'b0;
    logic [7:0]      rx_data = '0;
    logic            rx_done;
    logic            rd = 1'b0;
    logic [7:0]      rd_data;
    logic            empty;
    logic            full;
    logic [ADDR_W:0] count;
    logic            ovr;
    logic            ovr_clr = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [7:0] q[$];
    bit         m_done = 1'b0;
    bit         m_ovr  = 1'b0;
`ifdef RS232_RX_BUF_OVR_EN
    localparam bit OVR_ON = 1'b1;
`else
    localparam bit OVR_ON = 1'b0;
`endif

    rs232_rx_buf #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .rx_done(rx_done),
        .rd(rd), .rd_data(rd_data), .empty(empty), .full(full), .count(count),
        .ovr(ovr), .ovr_clr(ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(count), q.size());
        chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ".full"},  32'(full),  32'(q.size() == DEPTH));
        chk({tag, ".done"},  32'(rx_done), 32'(m_done));
        chk({tag, ".ovr"},   32'(ovr),   32'(m_ovr));
        if (q.size() != 0)
            chk({tag, ".rd_data"}, 32'(rd_data), 32'(q[0]));
    endtask

    // Apply one cycle of inputs, advance the model, then compare after the edge.
    task automatic step(input string tag, input logic r, input logic rdy, input logic [7:0] d,
                        input logic rdv, input logic clr);
        bit c, p, was_full, ov;
        rst = r; rx_rdy = rdy; rx_data = d; rd = rdv; ovr_clr = clr;
        if (r) begin
            q.delete();
            m_done = 1'b0;
            m_ovr  = 1'b0;
        end else begin
            c        = rdy && !m_done;
            p        = rdv && (q.size() != 0);
            was_full = (q.size() == DEPTH);
            ov       = 1'b0;
            if (p) void'(q.pop_front());
            if (c) begin
                if (!was_full || p) q.push_back(d);
                else ov = 1'b1;
            end
            m_done = c;
            if (OVR_ON) begin
                if (ov) m_ovr = 1'b1;
                else if (clr) m_ovr = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Receiver handshake: rx_rdy held through the cycle in which rx_done is seen.
    task automatic send(input string tag, input logic [7:0] d, input logic rdv);
        step(tag, 1'b0, 1'b1, d, rdv, 1'b0);
        step(tag, 1'b0, 1'b1, d, 1'b0, 1'b0);
        rx_rdy = 1'b0;
    endtask

    task automatic reset2();
        step("reset", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step("reset", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        #1;
        // Reset state
        reset2();
        chk("rst.empty_c", 32'(empty), 1);
        chk("rst.count_c", 32'(count), 0);

        // Single byte with one done pulse
        step("single", 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
        chk("single.done_c", 32'(rx_done), 1);
        chk("single.data_c", 32'(rd_data), 32'h A5);
        step("single_hold", 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
        chk("single.done_off", 32'(rx_done), 0);
        chk("single.count_c", 32'(count), 1);
        step("single_rd", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("single.empty_c", 32'(empty), 1);

        // Fill, drain, refill across the wrap point
        for (int i = 0; i < DEPTH; i++) send("fill", 8'(i), 1'b0);
        chk("fill.full_c", 32'(full), 1);
        chk("fill.count_c", 32'(count), DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain.seq", 32'(rd_data), i);
            step("drain", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        for (int i = 0; i < DEPTH; i++) send("refill", 8'(8'h10 + i), 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            chk("wrap.seq", 32'(rd_data), 32'h10 + i);
            step("wrap_drain", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Overrun on full
        for (int i = 0; i < DEPTH; i++) send("ovr_fill", 8'(i), 1'b0);
        step("ovr_send", 1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
        chk("ovr.done_c", 32'(rx_done), 1);
        chk("ovr.count_c", 32'(count), DEPTH);
        chk("ovr.head_c", 32'(rd_data), 0);
        chk("ovr.flag_c", 32'(ovr), 32'(OVR_ON));
        step("ovr_hold", 1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
        step("ovr_clr", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovr.clr_c", 32'(ovr), 0);

        // Simultaneous write and read while full
        step("sim", 1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
        chk("sim.count_c", 32'(count), DEPTH);
        chk("sim.ovr_c", 32'(ovr), 0);
        step("sim_hold", 1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH - 1; i++) step("sim_drain", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("sim.last_c", 32'(rd_data), 32'h77);
        step("sim_last", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Mid-operation reset, then read while empty
        for (int i = 0; i < 5; i++) send("mid_fill", 8'(8'h50 + i), 1'b0);
        step("mid_rst", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("mid.count_c", 32'(count), 0);
        chk("mid.empty_c", 32'(empty), 1);
        step("empty_rd", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step("empty_rd2", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("empty_rd.count_c", 32'(count), 0);

        // rx_rdy held through reset is captured on the first edge after it
        step("rst_rdy", 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
        step("post_rst", 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
        chk("post_rst.count_c", 32'(count), 1);
        chk("post_rst.data_c", 32'(rd_data), 32'h3C);
        step("post_rst_hold", 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);

        // Random traffic, writes biased to reach full and overrun
        for (int n = 0; n < 600; n++) begin
            step("rand", 1'b0, 1'($urandom_range(0, 3) != 0), 8'($urandom),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
